// File: rtl/pc_conf_parser.sv
// pc_conf_parser: routes PC downstream words to config registers, config channels or the bad-code counter
module pc_conf_parser #(
   parameter int Nconf = 16,
   parameter int Nreg  = 64,
   parameter int Nchan = 1,
   parameter int Ncode = 8,
   parameter int Nerr  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pc_in_v,
   input  logic [Ncode+Nconf-1:0] pc_in_d,
   output logic                   pc_in_a,
   input  logic [Nreg*Nconf-1:0]  conf_reg_reset_vals,
   output logic [Nreg*Nconf-1:0]  conf_reg_out,
   output logic [Nchan-1:0]       conf_chan_v,
   output logic [Nchan*Nconf-1:0] conf_chan_d,
   input  logic [Nchan-1:0]       conf_chan_a,
   output logic [Nerr-1:0]        bad_code_count
);
   if (Nreg + Nchan > 2**Ncode) begin : g_bad_params
      $error("pc_conf_parser: Nreg+Nchan exceeds the leaf code space");
   end
   localparam logic [Ncode:0] reg_lim  = (Ncode+1)'(Nreg);
   localparam logic [Ncode:0] chan_lim = (Ncode+1)'(Nreg + Nchan);
   logic [Ncode-1:0] code;
   logic [Ncode:0]   code_x;
   logic [Nconf-1:0] payload;
   logic             is_reg, is_chan, is_bad, xfer;
   logic [Nchan-1:0] sel, room;
   assign code    = pc_in_d[Ncode+Nconf-1:Nconf];
   assign code_x  = {1'b0, code};
   assign payload = pc_in_d[Nconf-1:0];
   assign is_reg  = code_x < reg_lim;
   assign is_chan = !is_reg && code_x < chan_lim;
   assign is_bad  = !is_reg && !is_chan;
   for (genvar i = 0; i < Nchan; i++) begin : g_sel
      localparam logic [Ncode:0] ci = (Ncode+1)'(Nreg + i);
      assign sel[i] = code_x == ci;
   end
   // A one-entry buffer has room when empty or being drained this cycle
   assign room = ~conf_chan_v | conf_chan_a;
   // Ack depends only on the code and buffer state, never on pc_in_v
   always_comb begin
      pc_in_a = !reset && (is_chan ? |(sel & room) : 1'b1);
      xfer    = pc_in_v && pc_in_a;
   end
   // Register bank: reload on reset, single-register write on REG transfer
   always_ff @(posedge clk)
      if (reset) conf_reg_out <= conf_reg_reset_vals;
      else if (xfer && is_reg) conf_reg_out[code*Nconf +: Nconf] <= payload;
   // Channel buffers: load on transfer, clear when drained without refill
   always_ff @(posedge clk)
      if (reset) conf_chan_v <= '0;
      else
         for (int i = 0; i < Nchan; i++)
            if (xfer && sel[i]) begin
               conf_chan_v[i]                 <= 1'b1;
               conf_chan_d[i*Nconf +: Nconf]  <= payload;
            end else if (conf_chan_a[i]) conf_chan_v[i] <= 1'b0;
   // Saturating count of discarded words
   always_ff @(posedge clk)
      if (reset) bad_code_count <= '0;
      else if (xfer && is_bad && bad_code_count != '1) bad_code_count <= bad_code_count + 1'b1;
endmodule

// File: doc/pc_conf_parser.md
Name: pc_conf_parser

Overview:
- Sits directly upstream of the config mapper. It receives PC downstream words and decodes each word's leaf code.
- Each word is routed to one of three places: a register-file write, one of Nchan serial config channels, or a discard with an error count.
- Outputs are a flat register bank (`conf_reg_out`) and packed channel outputs, both consumed by the mapper.

Parameters:
- Nconf, 16, payload / config register width
- Nreg, 64, number of config registers (leaf codes 0..Nreg-1)
- Nchan, 1, number of config channels (leaf codes Nreg..Nreg+Nchan-1)
- Ncode, 8, leaf code width; elaboration error if Nreg+Nchan > 2**Ncode
- Nerr, 16, error counter width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- pc_in_v  input  1  input word valid
- pc_in_d  input  Ncode+Nconf  {code[Ncode-1:0], payload[Nconf-1:0]}
- pc_in_a  output  1  input ack; a transfer occurs on any cycle with v && a
- conf_reg_reset_vals  input  Nreg*Nconf  per-register reset values, packed [Nreg-1:0][Nconf-1:0]
- conf_reg_out  output  Nreg*Nconf  current register contents, same packing
- conf_chan_v  output  Nchan  channel i word valid
- conf_chan_d  output  Nchan*Nconf  channel i payload, packed [Nchan-1:0][Nconf-1:0]
- conf_chan_a  input  Nchan  channel i ack
- bad_code_count  output  Nerr  saturating count of discarded words

Behaviour:
- Reset (synchronous, active-high; clk and reset as named above):
  - Every cycle reset is high: `conf_reg_out[k] <= conf_reg_reset_vals[k]` for all k, all `conf_chan_v <= 0`, `bad_code_count <= 0`.
  - `pc_in_a` = 0 while reset is high, so no transfer is taken.
  - Reset mid-operation discards any buffered channel word and takes priority over a concurrent write.
- Decode, using code = `pc_in_d[Ncode+Nconf-1:Nconf]`:
  - REG: code < Nreg.
  - CHAN(i): Nreg <= code < Nreg+Nchan, with i = code - Nreg.
  - BAD: all other codes.
- Ack (combinational from `pc_in_d`, buffer state and `conf_chan_a`, never from `pc_in_v`):
  - REG or BAD: `pc_in_a` = 1.
  - CHAN(i): `pc_in_a` = !`conf_chan_v[i]` || `conf_chan_a[i]`, so the buffer may refill on the same cycle it drains.
- REG transfer: `conf_reg_out[code] <= payload` at the clock edge. The new value is visible the following cycle (1-cycle latency). All other registers hold.
- CHAN(i) transfer:
  - Buffer i loads the payload and `conf_chan_v[i] <= 1`, so the output is valid on the next cycle.
  - Buffer i holds `conf_chan_d[i]` stable while `conf_chan_v[i]` && !`conf_chan_a[i]`.
  - Drain (v && a) with no refill gives `conf_chan_v[i] <= 0`.
  - Drain and refill on the same cycle gives v stays 1 and d takes the new payload.
  - Each buffer is one entry, which sustains 1 word/cycle when the consumer acks continuously.
- BAD transfer: the word is dropped and `bad_code_count` increments. The count saturates at 2**Nerr-1 and does not wrap.
- Channels are independent: a stalled channel i blocks only words addressed to i. Because input is in-order, it also head-of-line blocks later words.
- Payload bits are stored unmodified; there is no sign or width conversion.

Test Plan:
- Reset with `conf_reg_reset_vals[30]`=1 and `[31]`=3 -> after reset deasserts, `conf_reg_out[30]`=1, `[31]`=3, all `conf_chan_v`=0, `bad_code_count`=0, and `pc_in_a` was 0 throughout reset.
- Write code=22, payload=0x2710 -> `pc_in_a`=1, and on the next cycle `conf_reg_out[22]`=0x2710 with all other registers unchanged. A back-to-back write to code=22 with 0x0005 gives 0x0005 one cycle later.
- Stream 4 words code=64 (CHAN 0), payloads 1,2,3,4, with `conf_chan_a[0]` held 1 -> 4 consecutive transfers, and `conf_chan_d[0]` shows 1,2,3,4 on consecutive cycles starting 1 cycle after the first accept.
- Same stream with `conf_chan_a[0]`=0 -> first word buffered, `pc_in_a`=0 for word 2. Then release ack for 1 cycle -> word 2 accepted on that same cycle and d changes 1→2 with no bubble in v.
- Code=200 sent 3 times -> all acked, no register or channel change, `bad_code_count`=3. With Nerr=2 and 5 bad words, the count saturates at 3.
- Channel word buffered and unacked, then reset pulsed mid-stall -> `conf_chan_v[0]`=0 and registers reloaded from `conf_reg_reset_vals`. A write presented during the reset cycle is not acked and not applied.
